// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg: shared pipeline definitions for the fetch stage and its
// neighbours (hazard unit reuses the branch-select encodings).
//   - BS_* : branch-select encodings {BS_one,BS_zero}
//   - fetch_state_e : fetch FSM states
//   - default parameter values for the fetch unit
package fetch_unit_pkg;

    localparam logic [1:0] BS_INC  = 2'b00;  // sequential, no redirect
    localparam logic [1:0] BS_COND = 2'b01;  // conditional on Z^PS, target BrA
    localparam logic [1:0] BS_JREG = 2'b10;  // register jump, target RAA
    localparam logic [1:0] BS_BR   = 2'b11;  // unconditional, target BrA

    localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int unsigned MAX_WAIT_DEF = 15;

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_REDIR = 2'd3
    } fetch_state_e;

    // Sequential PC step; 32-bit wrap is intentional.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd1;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory req/ack bus.
//   addr  : fetch address (driven by fetch)
//   req   : fetch request (driven by fetch)
//   rdata : instruction word, meaningful only with ack (driven by memory)
//   ack   : accept/data-valid, ignored unless req is high (driven by memory)
interface fetch_unit_if;
    logic [31:0] addr;
    logic        req;
    logic [31:0] rdata;
    logic        ack;

    modport master (output addr, output req, input rdata, input ack);
    modport slave  (input addr, input req, output rdata, output ack);
endinterface

// File: rtl/fetch_unit_branch_select.sv
// branch_select: combinational redirect decode and target mux from the
// execute-stage branch controls. Shared by fetch and the hazard unit.
//   i_bs     : {BS_one,BS_zero}
//   i_ps     : branch polarity (0 = branch on zero, 1 = branch on nonzero)
//   i_z      : zero flag
//   i_bra    : PC-relative target
//   i_raa    : register jump target
//   o_taken  : redirect this cycle
//   o_target : redirect target (meaningful only when o_taken)
module branch_select
    import fetch_unit_pkg::*;
(
    input  logic [1:0]  i_bs,
    input  logic        i_ps,
    input  logic        i_z,
    input  logic [31:0] i_bra,
    input  logic [31:0] i_raa,
    output logic        o_taken,
    output logic [31:0] o_target
);

    always_comb begin
        o_taken  = 1'b0;
        o_target = i_bra;
        case (i_bs)
            BS_INC:  o_taken = 1'b0;
            BS_COND: o_taken = i_z ^ i_ps;
            BS_JREG: begin
                o_taken  = 1'b1;
                o_target = i_raa;
            end
            default: o_taken = 1'b1;  // BS_BR
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, fetches over the
// req/ack instruction-memory bus, presents IR/PC_1 to decode and applies
// execute-stage redirects. All state updates on the falling clock edge.
//   i_clk, i_rst         : clock (negedge active), async active-high reset
//   i_bra, i_raa         : branch / register-jump targets from execute
//   i_bs_one, i_bs_zero  : branch select
//   i_ps, i_z            : branch polarity and zero flag
//   i_stall              : hazard hold for fetch and decode
//   im                   : instruction-memory bus (master side)
//   o_ir, o_pc_1         : fetched instruction and its address + 1
//   o_ir_valid           : IR holds a real instruction
//   o_br_taken           : redirect taken this cycle (flush)
//   o_im_timeout         : sticky memory-timeout error
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_WORD = NOP_WORD_DEF,
    parameter int unsigned MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [31:0]       i_bra,
    input  logic [31:0]       i_raa,
    input  logic              i_bs_one,
    input  logic              i_bs_zero,
    input  logic              i_ps,
    input  logic              i_z,
    input  logic              i_stall,
    fetch_unit_if.master      im,
    output logic [31:0]       o_ir,
    output logic [31:0]       o_pc_1,
    output logic              o_ir_valid,
    output logic              o_br_taken,
    output logic              o_im_timeout
);

    localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_WAIT);

    fetch_state_e  r_state, w_state;
    logic [31:0]   r_pc, w_pc;
    logic [31:0]   r_ir, w_ir;
    logic [31:0]   r_pc_1, w_pc_1;
    logic          r_ir_valid, w_ir_valid;
    logic [CW-1:0] r_cnt, w_cnt;
    logic          r_timeout, w_timeout;

    logic          w_taken;
    logic [31:0]   w_target;
    logic          w_req;
    logic [CW-1:0] w_cnt_inc;

    branch_select u_bsel (
        .i_bs     ({i_bs_one, i_bs_zero}),
        .i_ps     (i_ps),
        .i_z      (i_z),
        .i_bra    (i_bra),
        .i_raa    (i_raa),
        .o_taken  (w_taken),
        .o_target (w_target)
    );

    // Request is a pure function of state so an async reset drops it
    // immediately; a stall withdraws (cancels) the request.
    assign w_req     = ((r_state == S_FETCH) || (r_state == S_WAIT)) && !i_stall;
    assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_RST;
            r_pc       <= RESET_PC;
            r_ir       <= NOP_WORD;
            r_pc_1     <= 32'h0;
            r_ir_valid <= 1'b0;
            r_cnt      <= '0;
            r_timeout  <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_pc       <= w_pc;
            r_ir       <= w_ir;
            r_pc_1     <= w_pc_1;
            r_ir_valid <= w_ir_valid;
            r_cnt      <= w_cnt;
            r_timeout  <= w_timeout;
        end
    end

    // Priority: redirect > stall > accept/wait.
    always_comb begin
        w_state    = r_state;
        w_pc       = r_pc;
        w_ir       = r_ir;
        w_pc_1     = r_pc_1;
        w_ir_valid = r_ir_valid;
        w_cnt      = r_cnt;
        w_timeout  = r_timeout;

        if (w_taken) begin
            // Squash the delay-slot successor; any same-cycle ack is dropped.
            w_state    = S_REDIR;
            w_pc       = w_target;
            w_ir       = NOP_WORD;
            w_ir_valid = 1'b0;
            w_cnt      = '0;
        end else if (!i_stall) begin
            case (r_state)
                S_RST, S_REDIR: begin
                    w_state    = S_FETCH;
                    w_ir       = NOP_WORD;
                    w_ir_valid = 1'b0;
                end
                default: begin
                    if (im.ack) begin
                        w_state    = S_FETCH;
                        w_ir       = im.rdata;
                        w_pc       = pc_inc(r_pc);
                        w_pc_1     = pc_inc(r_pc);
                        w_ir_valid = 1'b1;
                        w_cnt      = '0;
                    end else begin
                        w_state    = S_WAIT;
                        w_ir       = NOP_WORD;
                        w_ir_valid = 1'b0;
                        w_cnt      = w_cnt_inc;
                        if (w_cnt_inc == CNT_MAX)
                            w_timeout = 1'b1;
                    end
                end
            endcase
        end
    end

    assign im.addr      = r_pc;
    assign im.req       = w_req;
    assign o_ir         = r_ir;
    assign o_pc_1       = r_pc_1;
    assign o_ir_valid   = r_ir_valid;
    assign o_br_taken   = w_taken;
    assign o_im_timeout = r_timeout;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RPC  = 32'h0000_0010;
    localparam logic [31:0] NOP  = 32'h0000_0000;
    localparam int          MAXW = 15;

    logic        clk = 1'b1;
    logic        rst = 1'b0;
    logic [31:0] bra = 32'h0, raa = 32'h0;
    logic        bs1 = 1'b0, bs0 = 1'b0, ps = 1'b0, z = 1'b0, stall = 1'b0;
    logic [31:0] ir, pc1;
    logic        irv, brt, tmo;

    fetch_unit_if im_bus();

    fetch_unit #(.RESET_PC(RPC), .NOP_WORD(NOP), .MAX_WAIT(MAXW)) dut (
        .i_clk(clk), .i_rst(rst), .i_bra(bra), .i_raa(raa),
        .i_bs_one(bs1), .i_bs_zero(bs0), .i_ps(ps), .i_z(z), .i_stall(stall),
        .im(im_bus), .o_ir(ir), .o_pc_1(pc1), .o_ir_valid(irv),
        .o_br_taken(brt), .o_im_timeout(tmo)
    );

    always #5 clk = ~clk;  // negedges at 5,15,...; inputs change at posedge+1

    int n_chk = 0;
    int n_fail = 0;

    // Expected combinational view before the edge, and registered view after.
    typedef struct { logic req; logic [31:0] addr; logic br; } pre_t;
    typedef struct { logic [31:0] pc; logic [31:0] ir; logic [31:0] pc1; logic vld; logic to; } post_t;
    pre_t  preq[$];
    post_t postq[$];

    // Reference model: architectural view of the fetch stage.
    logic [31:0] m_pc, m_ir, m_pc1;
    logic        m_vld, m_to;
    bit          m_bubble;  // next edge only (re)starts fetching
    int          m_wait;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_pc = RPC; m_ir = NOP; m_pc1 = 32'h0; m_vld = 1'b0; m_to = 1'b0;
        m_bubble = 1'b1; m_wait = 0;
    endfunction

    task automatic cyc(input logic [1:0] bs, input logic p, input logic zz,
                       input logic [31:0] ba, input logic [31:0] ra,
                       input logic st, input logic ak, input logic [31:0] rd);
        pre_t  e;
        post_t o;
        bit    taken;
        logic [31:0] tgt;
        @(posedge clk); #1;
        rst = 1'b0; {bs1, bs0} = bs; ps = p; z = zz; bra = ba; raa = ra; stall = st;
        im_bus.ack = ak; im_bus.rdata = rd;

        if (bs == 2'b00)      taken = 1'b0;
        else if (bs == 2'b01) taken = (zz != p);
        else                  taken = 1'b1;
        tgt = (bs == 2'b10) ? ra : ba;

        e.req = !m_bubble && !st; e.addr = m_pc; e.br = taken;
        preq.push_back(e);

        if (taken) begin
            m_pc = tgt; m_ir = NOP; m_vld = 1'b0; m_wait = 0; m_bubble = 1'b1;
        end else if (st) begin
            // everything holds
        end else if (m_bubble) begin
            m_bubble = 1'b0; m_vld = 1'b0; m_ir = NOP;
        end else if (ak) begin
            m_ir = rd; m_pc = m_pc + 32'd1; m_pc1 = m_pc; m_vld = 1'b1; m_wait = 0;
        end else begin
            m_vld = 1'b0; m_ir = NOP;
            if (m_wait < MAXW) m_wait++;
            if (m_wait >= MAXW) m_to = 1'b1;
        end

        o.pc = m_pc; o.ir = m_ir; o.pc1 = m_pc1; o.vld = m_vld; o.to = m_to;
        postq.push_back(o);
    endtask

    task automatic go(input int n, input logic ak);
        for (int i = 0; i < n; i++) cyc(2'b00, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, ak, $urandom);
    endtask

    // Monitor: pops the expectation whenever the DUT presents a cycle's outputs.
    initial begin : mon
        pre_t  e;
        post_t o;
        forever begin
            @(posedge clk); #3;
            if (preq.size() > 0) begin
                e = preq.pop_front();
                check32("im_req", {31'b0, im_bus.req}, {31'b0, e.req});
                check32("im_addr", im_bus.addr, e.addr);
                check32("br_taken", {31'b0, brt}, {31'b0, e.br});
            end
            @(negedge clk); #1;
            if (postq.size() > 0) begin
                o = postq.pop_front();
                check32("pc", im_bus.addr, o.pc);
                check32("ir", ir, o.ir);
                check32("pc_1", pc1, o.pc1);
                check32("ir_valid", {31'b0, irv}, {31'b0, o.vld});
                check32("timeout", {31'b0, tmo}, {31'b0, o.to});
            end
        end
    end

    initial begin
        im_bus.ack = 1'b0; im_bus.rdata = 32'h0;
        #1 rst = 1'b1;
        #1;
        model_reset();
        check32("rst_req", {31'b0, im_bus.req}, 32'h0);
        check32("rst_addr", im_bus.addr, RPC);
        check32("rst_ir", ir, NOP);
        check32("rst_pc1", pc1, 32'h0);
        check32("rst_vld", {31'b0, irv}, 32'h0);
        check32("rst_timeout", {31'b0, tmo}, 32'h0);

        // Zero-wait start-up from 0x10
        go(4, 1'b1);
        // Conditional branch on zero: taken, then not taken
        cyc(2'b01, 1'b0, 1'b1, 32'h40, 32'h0, 1'b0, 1'b1, $urandom);
        go(3, 1'b1);
        cyc(2'b01, 1'b0, 1'b0, 32'h44, 32'h0, 1'b0, 1'b1, $urandom);
        go(2, 1'b1);
        // Register jump with ack and stall together: ack data dropped
        cyc(2'b10, 1'b0, 1'b0, 32'h0, 32'h80, 1'b1, 1'b1, $urandom);
        go(3, 1'b1);
        // Wait states at 0x20
        cyc(2'b11, 1'b0, 1'b0, 32'h20, 32'h0, 1'b0, 1'b1, $urandom);
        go(1, 1'b1);
        go(3, 1'b0);
        go(1, 1'b1);
        // Timeout after MAX_WAIT missed cycles, sticky after a later ack
        go(MAXW, 1'b0);
        @(negedge clk); #1;
        check32("timeout_set", {31'b0, tmo}, 32'h1);
        go(2, 1'b1);
        @(negedge clk); #1;
        check32("timeout_sticky", {31'b0, tmo}, 32'h1);
        // PC wrap
        cyc(2'b11, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1'b0, 1'b1, $urandom);
        go(3, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [1:0] bs;
            bs = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            cyc(bs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                ($urandom_range(0, 5) == 0), ($urandom_range(0, 2) != 0), $urandom);
        end

        // Async reset while waiting: request must drop without a clock edge
        go(2, 1'b0);
        @(posedge clk); #1;
        stall = 1'b0; im_bus.ack = 1'b0;
        check32("req_before_rst", {31'b0, im_bus.req}, 32'h1);
        rst = 1'b1;
        #1;
        check32("req_async_rst", {31'b0, im_bus.req}, 32'h0);
        check32("timeout_cleared", {31'b0, tmo}, 32'h0);
        check32("addr_async_rst", im_bus.addr, RPC);
        model_reset();
        @(negedge clk);
        go(4, 1'b1);

        // Drain the scoreboard, bounded
        for (int i = 0; i < 4 && (preq.size() > 0 || postq.size() > 0); i++) @(posedge clk);
        #8;
        n_chk++;
        if (preq.size() != 0 || postq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d/%0d entries left, required 0/0", preq.size(), postq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
